// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational carry-lookahead slice: every internal carry is a flat sum of
// generate/propagate products rather than a rippled chain.
module cla_chunk #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          pg,
    output logic          gg
);

    logic [CW-1:0] p;
    logic [CW-1:0] g;
    logic [CW:0]   c;
    logic          prod;
    logic          acc;

    assign p  = a ^ b;
    assign g  = a & b;
    assign pg = &p;
    assign s  = p ^ c[CW-1:0];

    always_comb begin
        c    = '0;
        prod = 1'b1;
        acc  = 1'b0;
        for (int i = 0; i <= CW; i++) begin
            prod = 1'b1;
            acc  = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i] = acc | (prod & ci);
        end
        // After the last pass acc holds the generate term of the whole slice.
        gg = acc;
        co = c[CW];
    end

endmodule

// File: rtl/cla_pipe.sv
// Pipelined add/sub: bank 0 registers the operands, bank k+1 holds the result
// after chunk k; a single global enable stalls every bank together.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    logic              en;
    logic [STAGES:0]   v_q;
    logic [STAGES:0]   c_q;
    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  b_q    [STAGES];
    logic [WIDTH-1:0]  r_q    [1:STAGES];
    logic [WIDTH-1:0]  r_base [STAGES];
    logic [WIDTH-1:0]  r_next [STAGES];
    logic [CW-1:0]     s      [STAGES];
    logic [STAGES-1:0] cout;
    logic [STAGES-1:0] gp;
    logic [STAGES-1:0] gg;
    logic              ovf_q;
    logic              zero_q;
    logic              ovf_d;
    logic              zero_d;
    logic              unused_pg;

    assign en        = !v_q[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES];
    assign z         = r_q[STAGES];
    assign co        = c_q[STAGES];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign unused_pg = ^{gp, gg};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_chunk #(
            .CW (CW)
        ) u_chunk (
            .a  (a_q[k][k*CW +: CW]),
            .b  (b_q[k][k*CW +: CW]),
            .ci (c_q[k]),
            .s  (s[k]),
            .co (cout[k]),
            .pg (gp[k]),
            .gg (gg[k])
        );
    end

    assign r_base[0] = '0;
    for (genvar k = 1; k < STAGES; k++) begin : g_base
        assign r_base[k] = r_q[k];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_next[k]               = r_base[k];
            r_next[k][k*CW +: CW]   = s[k];
        end
    end

    assign zero_d = ~|r_next[STAGES-1];
    assign ovf_d  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                    (r_next[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                r_q[k] <= '0;
            end
        end else if (en) begin
            // en implies in_ready, so in_valid alone marks a transfer.
            v_q    <= {v_q[STAGES-1:0], in_valid};
            c_q    <= {cout, ci};
            a_q[0] <= a;
            b_q[0] <= (op == OP_SUB) ? ~b : b;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 1; k <= STAGES; k++) begin
                r_q[k] <= r_next[k-1];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

`ifdef FORMAL
    localparam int unsigned Depth = STAGES + 2;

    logic [WIDTH:0] ref_q [Depth];
    int unsigned    wr_q;
    int unsigned    rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= 0;
            rd_q <= 0;
        end else begin
            if (in_valid && in_ready) begin
                ref_q[wr_q] <= {1'b0, a} + {1'b0, ((op == OP_SUB) ? ~b : b)} +
                               {{WIDTH{1'b0}}, ci};
                wr_q        <= (wr_q + 1) % Depth;
            end
            if (out_valid && out_ready) begin
                rd_q <= (rd_q + 1) % Depth;
            end
        end
    end

    always_comb begin
        if (!rst && out_valid) begin
            assert ({co, z} == ref_q[rd_q]);
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable({z, co, ovf, zero})));
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: directed corner cases, random streams with backpressure
// and mid-flight reset, against a plain-arithmetic reference model.
module tb_cla_pipe;
    import cla_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    op_e         op;

    logic        iv4, ir4, ov4, or4, co4, ovf4, zero4;
    logic [31:0] z4;
    logic        iv1, ir1, ov1, or1, co1, ovf1, zero1;
    logic [31:0] z1;
    logic        iv8, ir8, ov8, or8, co8, ovf8, zero8;
    logic [15:0] z8;

    int          tests = 0;
    int          fails = 0;
    int          got4  = 0;
    logic [34:0] q4[$];
    logic [34:0] q1[$];
    logic [34:0] q8[$];

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(32), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .ci(ci),
        .op(op), .out_valid(ov4), .out_ready(or4), .z(z4), .co(co4), .ovf(ovf4), .zero(zero4)
    );

    cla_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .ci(ci),
        .op(op), .out_valid(ov1), .out_ready(or1), .z(z1), .co(co1), .ovf(ovf1), .zero(zero1)
    );

    cla_pipe #(.WIDTH(16), .STAGES(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[15:0]), .b(b[15:0]),
        .ci(ci), .op(op), .out_valid(ov8), .out_ready(or8), .z(z8), .co(co8), .ovf(ovf8),
        .zero(zero8)
    );

    // Returns {ovf, zero, co, z} for a w-bit add of a + (sub ? ~b : b) + cin.
    function automatic logic [34:0] ref_model(input logic [31:0] aa, input logic [31:0] bb,
                                              input logic cin, input logic sub, input int w);
        longint unsigned mask, ua, ub, sum, zz;
        longint          lim, sa, sb, ss;
        logic            cout, v;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, aa} & mask;
        ub   = (sub ? ~{32'b0, bb} : {32'b0, bb}) & mask;
        sum  = ua + ub + {63'b0, cin};
        zz   = sum & mask;
        cout = sum[w];
        lim  = longint'(64'd1 << (w - 1));
        sa   = (longint'(ua) >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
        sb   = (longint'(ub) >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
        ss   = sa + sb + longint'({63'b0, cin});
        v    = (ss >= lim) || (ss < -lim);
        return {v, (zz == 0), cout, zz[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        logic [31:0] r;
        a  = $urandom();
        b  = $urandom();
        r  = $urandom();
        ci = r[0];
        op = r[1] ? OP_SUB : OP_ADD;
        // Bias some operands toward the carry/overflow corners.
        if (r[4:2] == 3'd0) b = ~a;
        if (r[4:2] == 3'd1) a = 32'h7FFF_FFFF;
    endtask

    // Called at a negedge with inputs set; scores transfers, then moves to the next negedge.
    task automatic cycle();
        #1;
        if (ov4 && or4) begin
            if (q4.size() == 0) chk("spurious4", {35'b0, ov4}, 36'd0);
            else begin
                chk("res4", {1'b0, ovf4, zero4, co4, z4}, {1'b0, q4.pop_front()});
                got4++;
            end
        end
        if (ov1 && or1) begin
            if (q1.size() == 0) chk("spurious1", {35'b0, ov1}, 36'd0);
            else chk("res1", {1'b0, ovf1, zero1, co1, z1}, {1'b0, q1.pop_front()});
        end
        if (ov8 && or8) begin
            if (q8.size() == 0) chk("spurious8", {35'b0, ov8}, 36'd0);
            else chk("res8", {1'b0, ovf8, zero8, co8, 16'h0, z8}, {1'b0, q8.pop_front()});
        end
        if (iv4 && ir4) q4.push_back(ref_model(a, b, ci, op == OP_SUB, 32));
        if (iv1 && ir1) q1.push_back(ref_model(a, b, ci, op == OP_SUB, 32));
        if (iv8 && ir8) q8.push_back(ref_model(a, b, ci, op == OP_SUB, 16));
        @(negedge clk);
    endtask

    task automatic drain();
        iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        or4 = 1'b1; or1 = 1'b1; or8 = 1'b1;
        for (int i = 0; i < 40 && (q4.size() + q1.size() + q8.size()) != 0; i++) cycle();
        chk("drain", 36'(q4.size() + q1.size() + q8.size()), 36'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                            input logic cin, input logic sub, input logic [34:0] exp);
        int n;
        a = aa; b = bb; ci = cin; op = sub ? OP_SUB : OP_ADD;
        iv4 = 1'b1; or4 = 1'b1;
        cycle();
        iv4 = 1'b0;
        n = 1;
        while (!ov4 && n < 20) begin
            cycle();
            n++;
        end
        chk({tag, "_val"}, {1'b0, ovf4, zero4, co4, z4}, {1'b0, exp});
        chk({tag, "_lat"}, 36'(n - 1), 36'd4);
        cycle();
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] r;

        rst = 1'b1;
        a = '0; b = '0; ci = 1'b0; op = OP_ADD;
        iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        or4 = 1'b1; or1 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {35'b0, ir4}, 36'd1);
        chk("rst_outputs", {ov4, ovf4, zero4, co4, z4}, 36'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {33'b0, ir4, ir1, ir8}, 36'd7);

        directed("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 32'h0});
        directed("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 32'h8000_0000});
        directed("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        directed("sub_eq", 32'd7, 32'd7, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 32'h0});
        directed("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b1, {1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF});

        // Back-to-back stream: one result per cycle after the fill.
        base = got4;
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            iv4 = 1'b1;
            cycle();
        end
        drain();
        chk("stream_count", 36'(got4 - base), 36'd100);

        // Consumer stalls for 10 cycles mid-stream.
        base = got4;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            iv4 = 1'b1;
            or4 = !(i >= 15 && i < 25);
            if (i >= 15 && i < 25) begin
                #1;
                chk("stall_in_ready", {35'b0, ir4}, 36'd0);
                chk("stall_hold", {ov4, ovf4, zero4, co4, z4}, {1'b1, q4[0]});
            end
            cycle();
        end
        drain();
        chk("stall_count", 36'(got4 - base), 36'(40 - 10));

        // Random valid/ready on both sides.
        for (int i = 0; i < 200; i++) begin
            rand_ops();
            r   = $urandom();
            iv4 = r[0] | r[1];
            or4 = r[2] | r[3];
            cycle();
        end
        drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            iv4 = 1'b1;
            cycle();
        end
        iv4 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q4.delete();
        chk("mid_rst_out_valid", {35'b0, ov4}, 36'd0);
        chk("mid_rst_in_ready", {35'b0, ir4}, 36'd1);
        base = got4;
        for (int i = 0; i < 10; i++) cycle();
        chk("mid_rst_no_stale", 36'(got4 - base), 36'd0);

        // Latency of the single-stage and eight-stage variants.
        rand_ops();
        iv1 = 1'b1;
        cycle();
        iv1 = 1'b0;
        n = 1;
        while (!ov1 && n < 20) begin cycle(); n++; end
        chk("lat_stages1", 36'(n - 1), 36'd1);
        cycle();
        rand_ops();
        iv8 = 1'b1;
        cycle();
        iv8 = 1'b0;
        n = 1;
        while (!ov8 && n < 30) begin cycle(); n++; end
        chk("lat_stages8", 36'(n - 1), 36'd8);
        cycle();

        // Streams on the other two configurations, the second half with backpressure.
        for (int i = 0; i < 200; i++) begin
            rand_ops();
            r   = $urandom();
            iv1 = 1'b1;
            iv8 = 1'b1;
            or1 = (i < 100) || r[0] || r[1];
            or8 = (i < 100) || r[2] || r[3];
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational carry-lookahead adder.
- Adds or subtracts two WIDTH-bit operands with carry-in.
- The carry chain is split into STAGES registered chunks. Each chunk is a carry-lookahead slice.
- Uses a valid/ready handshake with full backpressure, sustains one operation per cycle, and produces carry, signed-overflow and zero flags.
- Sits between the operand-issue logic and the result-writeback logic of the datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages and carry chunks; 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- op  input  1  cla_pkg::op_e; OP_ADD=0, OP_SUB=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- z  output  WIDTH  sum/difference.
- co  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  z == 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Arithmetic:
  - OP_ADD: {co,z} = a + b + ci.
  - OP_SUB: {co,z} = a + ~b + ci. Callers pass ci=1 for a true a−b; co=1 means no borrow (a ≥ b unsigned when ci=1).
  - ovf = (a_msb == b'_msb) && (z_msb != a_msb), where b' is the inverted b for SUB.
  - zero = ~|z.
- Pipeline:
  - Stage k (0..STAGES-1) computes chunk k (bits k*CW .. k*CW+CW-1) with a CLA slice, using the carry registered from stage k-1. Stage 0 uses ci.
  - Upper operand chunks are carried forward in stage registers, unmodified, until their stage.
  - Lower result chunks are carried forward until output.
- Latency: STAGES cycles from an accepted input (in_valid && in_ready at edge n) to out_valid at edge n+STAGES, provided there is no stall.
- Handshake:
  - Global enable en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - When en=0 every stage register, including the valid bits, holds.
  - When en=1 all stages advance; a stage with no transfer receives a bubble (valid=0).
  - Outputs z/co/ovf/zero are registered and held stable while out_valid && !out_ready.
  - Bubbles are allowed anywhere. A result is never dropped or duplicated.
- Reset: all stage valid bits, out_valid, z, co, ovf and zero go to 0. in_ready=1 during and after reset. An in-flight operation is discarded silently.
- Boundary cases:
  - STAGES=1 gives a single registered CLA with latency 1.
  - Simultaneous accept and output-consume in the same cycle is full throughput.
  - out_ready=0 with a full pipe causes in_ready=0 until the result is consumed.
- Formal:
  - Under FORMAL, assert that each output equals a reference model {co,z} computed from a shadow FIFO of accepted operands.
  - Assert that the output is stable during stall.

Decomposition:
- cla_pkg: op_e enum (OP_ADD, OP_SUB); localparam helper function for chunk width; stage payload struct parametrisation is kept in the module.
- Sub-module cla_chunk #(CW):
  - Combinational CLA slice.
  - Inputs: a, b, ci.
  - Outputs: s, co, group p, group g.
  - Instantiated STAGES times in a generate loop.
- Top level holds only registers, the handshake and the flag logic.

Test Plan:
- WIDTH=32, STAGES=4: a=0xFFFF_FFFF, b=1, ci=0, op=ADD → after 4 cycles z=0, co=1, zero=1, ovf=0.
- a=0x7FFF_FFFF, b=1, ADD → z=0x8000_0000, co=0, ovf=1, zero=0. a=5, b=7, SUB, ci=1 → z=0xFFFF_FFFE, co=0, ovf=0.
- Back-to-back stream of 100 random ops with in_valid=1 and out_ready=1 → 100 results in order, one per cycle after 4-cycle fill; all match the reference model.
- Hold out_ready=0 for 10 cycles mid-stream → in_ready falls once the pipe is full; z and flags stay constant; no result is lost on release; order is preserved.
- Assert rst for one cycle while 3 ops are in flight → out_valid=0 the next cycle; in_ready=1; no stale result appears afterwards.
- Repeat the random stream for STAGES=1 (latency 1) and STAGES=8 with WIDTH=16 → all results correct.
